// File: rtl/additive_pkg.sv
// Shared types and width helpers for the additive voice engine.
package additive_pkg;

  localparam int DEF_HARMONICS       = 64;
  localparam int DEF_SAMPLE_INTERVAL = 1500;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    CHECK  = 3'd2,
    ADDR   = 3'd3,
    WAIT   = 3'd4,
    MAC    = 3'd5,
    FINISH = 3'd6,
    DONE   = 3'd7
  } state_t;

  // Headroom for HARMONICS full-scale products plus a sign bit.
  function automatic int acc_bits(input int lut_bits, input int scale_bits, input int harmonics);
    return lut_bits + scale_bits + $clog2(harmonics) + 1;
  endfunction

  function automatic int cnt_bits(input int harmonics);
    return $clog2(harmonics) + 1;
  endfunction

  localparam int ACC_BITS = acc_bits(16, 7, DEF_HARMONICS);
  localparam int CNT_BITS = cnt_bits(DEF_HARMONICS);

endpackage

// File: rtl/harmonic_phase_ram.sv
// Per-partial phase store: single port, registered read, write enable.
module harmonic_phase_ram
  import additive_pkg::*;
#(
  parameter  int DEPTH = DEF_HARMONICS,
  parameter  int WIDTH = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are never reset; the owner masks stale entries with valid bits.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/additive_voice.sv
// Additive-synthesis voice: sums up to HARMONICS sine partials per sample
// period and publishes a saturated offset-binary word with a send strobe.
module additive_voice
  import additive_pkg::*;
#(
  parameter  int HARMONICS       = DEF_HARMONICS,
  parameter  int PHASE_BITS      = 24,
  parameter  int LUT_ADDR_BITS   = 11,
  parameter  int LUT_BITS        = 16,
  parameter  int SCALE_BITS      = 7,
  parameter  int OUT_BITS        = 16,
  parameter  int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
  localparam int CNT_W           = cnt_bits(HARMONICS)
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic [PHASE_BITS-1:0]    i_phase_inc,
  input  logic [CNT_W-1:0]         i_harm_count,
  input  logic [SCALE_BITS-1:0]    i_decay,
  input  logic [2:0]               i_shift,
  input  logic                     i_sync,
  output logic [LUT_ADDR_BITS-1:0] o_lut_addr,
  input  logic [LUT_BITS-1:0]      i_lut_data,
  output logic [OUT_BITS-1:0]      o_sample,
  output logic                     o_valid,
  output logic [CNT_W-1:0]         o_active,
  output logic                     o_overrun,
  output state_t                   o_dbg_state
);

  localparam int IDX_W   = $clog2(HARMONICS);
  localparam int ACC_W   = acc_bits(LUT_BITS, SCALE_BITS, HARMONICS);
  localparam int PROD_W  = LUT_BITS + SCALE_BITS + 1;
  localparam int TIMER_W = $clog2(SAMPLE_INTERVAL);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [TIMER_W-1:0]     r_timer;
  logic                   w_tick;
  logic                   r_sync_seen;
  logic [HARMONICS-1:0]   r_valid;

  logic [PHASE_BITS-1:0]  r_phase_inc;
  logic [CNT_W-1:0]       r_harm;
  logic [SCALE_BITS-1:0]  r_decay;
  logic [2:0]             r_shift;

  logic [PHASE_BITS:0]    r_inc;
  logic [SCALE_BITS-1:0]  r_scale;
  logic [CNT_W-1:0]       r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic [OUT_BITS-1:0]    r_result;
  logic [LUT_ADDR_BITS-1:0] r_lut_addr;

  logic                   w_stop;
  logic                   w_ram_we;
  logic [IDX_W-1:0]       w_idx;
  logic [PHASE_BITS-1:0]  w_ram_rdata;
  logic [PHASE_BITS-1:0]  w_phase;
  logic [PHASE_BITS-1:0]  w_phase_next;
  logic signed [PROD_W-1:0] w_prod;
  logic [4:0]             w_shamt;
  logic signed [ACC_W-1:0] w_shifted;
  logic [OUT_BITS-1:0]    w_sat;
  logic [OUT_BITS-1:0]    w_result;

  assign w_tick       = (r_timer == TIMER_W'(SAMPLE_INTERVAL - 1));
  assign w_idx        = r_k[IDX_W-1:0];
  assign w_phase      = r_valid[w_idx] ? w_ram_rdata : '0;
  assign w_phase_next = w_phase + r_inc[PHASE_BITS-1:0];
  assign w_prod       = $signed(i_lut_data) * $signed({1'b0, r_scale});
  assign w_shamt      = 5'(SCALE_BITS) + 5'(r_shift);
  assign w_shifted    = r_acc >>> w_shamt;
  assign o_lut_addr   = r_lut_addr;
  assign o_dbg_state  = r_state;

  // Stop on harmonic limit, Nyquist (any inc bit at or above the half-range), or silence.
  assign w_stop = (r_k == r_harm) || (r_inc[PHASE_BITS:PHASE_BITS-1] != 2'b00) ||
                  (r_scale == '0);

  harmonic_phase_ram #(
    .DEPTH (HARMONICS),
    .WIDTH (PHASE_BITS)
  ) u_phase_ram (
    .clock   (clock),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (w_phase_next),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_tick) begin
      w_next = SETUP;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        SETUP:   w_next = CHECK;
        CHECK:   w_next = w_stop ? FINISH : ADDR;
        ADDR:    w_next = WAIT;
        WAIT:    w_next = MAC;
        MAC:     w_next = CHECK;
        FINISH:  w_next = DONE;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  // The phase RAM is read while in CHECK, so its data is ready in ADDR.
  always_comb begin
    w_ram_we = 1'b0;
    if (r_state == ADDR) w_ram_we = 1'b1;
  end

  always_comb begin
    w_sat = w_shifted[OUT_BITS-1:0];
    if (w_shifted > SAT_MAX)      w_sat = SAT_MAX[OUT_BITS-1:0];
    else if (w_shifted < SAT_MIN) w_sat = SAT_MIN[OUT_BITS-1:0];
    w_result = {~w_sat[OUT_BITS-1], w_sat[OUT_BITS-2:0]};
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      o_sample    <= {1'b1, {(OUT_BITS-1){1'b0}}};
      o_valid     <= 1'b0;
      o_active    <= '0;
      o_overrun   <= 1'b0;
      r_sync_seen <= 1'b0;
      r_valid     <= '0;
      r_phase_inc <= '0;
      r_harm      <= '0;
      r_decay     <= '0;
      r_shift     <= '0;
      r_inc       <= '0;
      r_scale     <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_result    <= {1'b1, {(OUT_BITS-1){1'b0}}};
      r_lut_addr  <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_sync) r_sync_seen <= 1'b1;

      // Outside DONE the previous word stays on o_sample; IDLE has nothing pending.
      if (w_tick) begin
        o_valid <= 1'b1;
        if (r_state == DONE) begin
          o_sample <= r_result;
          o_active <= r_k;
        end else if (r_state != IDLE) begin
          o_overrun <= 1'b1;
        end
      end

      case (r_state)
        SETUP: begin
          r_phase_inc <= i_phase_inc;
          r_harm      <= (i_harm_count > CNT_W'(HARMONICS)) ? CNT_W'(HARMONICS) : i_harm_count;
          r_decay     <= i_decay;
          r_shift     <= i_shift;
          r_inc       <= {1'b0, i_phase_inc};
          r_scale     <= '1;
          r_k         <= '0;
          r_acc       <= '0;
          if (r_sync_seen || i_sync) begin
            r_valid     <= '0;
            r_sync_seen <= 1'b0;
          end
        end
        ADDR: begin
          r_lut_addr     <= w_phase[PHASE_BITS-1 -: LUT_ADDR_BITS];
          r_valid[w_idx] <= 1'b1;
        end
        MAC: begin
          r_acc   <= r_acc + ACC_W'(w_prod);
          r_k     <= r_k + CNT_W'(1);
          r_inc   <= r_inc + {1'b0, r_phase_inc};
          r_scale <= (r_scale > r_decay) ? (r_scale - r_decay) : '0;
        end
        FINISH: r_result <= w_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_additive_voice.sv
// Directed bench for additive_voice with a registered LUT model (ramp or constant).
module tb_additive_voice;
  import additive_pkg::*;

  localparam int SI = 1500;

  logic        clock = 1'b0;
  logic        rstn  = 1'b0;
  logic [23:0] phase_inc;
  logic [6:0]  harm_count;
  logic [6:0]  decay;
  logic [2:0]  shift;
  logic        sync;
  logic [10:0] lut_addr;
  logic [15:0] lut_data = 16'd0;
  logic [15:0] sample;
  logic        valid;
  logic [6:0]  active;
  logic        overrun;
  state_t      dbg_state;

  logic        lut_ramp;
  logic [15:0] lut_const;
  int          total = 0;
  int          bad   = 0;

  // Clock / LUT model
  always #5 clock = ~clock;

  always @(posedge clock) lut_data <= lut_ramp ? {lut_addr, 5'b0} : lut_const;

  additive_voice dut (
    .clock        (clock),
    .rstn         (rstn),
    .i_phase_inc  (phase_inc),
    .i_harm_count (harm_count),
    .i_decay      (decay),
    .i_shift      (shift),
    .i_sync       (sync),
    .o_lut_addr   (lut_addr),
    .i_lut_data   (lut_data),
    .o_sample     (sample),
    .o_valid      (valid),
    .o_active     (active),
    .o_overrun    (overrun),
    .o_dbg_state  (dbg_state)
  );

  function automatic logic [15:0] exp_sample(input longint sum, input int sh);
    longint r;
    r = sum >>> (7 + sh);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r + 32768);
  endfunction

  // Drivers
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!valid && n < 3 * SI);
    if (!valid) begin
      total++; bad++;
      $display("FAIL valid_timeout: no o_valid after %0d clocks", n);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clock);
    rstn = 1'b1;
  endtask

  task automatic set_cfg(input logic [23:0] inc, input logic [6:0] hc, input logic [6:0] dc,
                         input logic [2:0] sh, input logic ramp, input logic [15:0] cval);
    int n;
    repeat (3) @(negedge clock);
    phase_inc = inc; harm_count = hc; decay = dc; shift = sh;
    lut_ramp = ramp; lut_const = cval;
    wait_valid(n);
    wait_valid(n);
  endtask

  // Tests
  task automatic test_reset();
    int n;
    rstn = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (sample !== 16'd32768) begin bad++; $display("FAIL rst_sample: got %0d want 32768", sample); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", valid); end
    total++; if (active !== 7'd0) begin bad++; $display("FAIL rst_active: got %0d want 0", active); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
    total++; if (lut_addr !== 11'd0) begin bad++; $display("FAIL rst_lut_addr: got %0d want 0", lut_addr); end
    rstn = 1'b1;
    wait_valid(n);
    total++; if (n !== SI) begin bad++; $display("FAIL first_tick: got %0d clocks want %0d", n, SI); end
    total++; if (sample !== 16'd32768) begin bad++; $display("FAIL idle_republish: got %0d want 32768", sample); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL idle_overrun: got %0b want 0", overrun); end
    @(negedge clock);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL valid_width: got %0b want 0", valid); end
    wait_valid(n);
    total++; if (n !== SI - 1) begin bad++; $display("FAIL tick_period: got %0d want %0d", n + 1, SI); end
  endtask

  task automatic test_single();
    int n;
    phase_inc = 24'd1 << 18; harm_count = 7'd1; decay = 7'd0; shift = 3'd0;
    lut_ramp = 1'b1;
    do_reset();
    wait_valid(n);
    for (int s = 0; s < 4; s++) begin
      wait_valid(n);
      total++; if (sample !== exp_sample(longint'(1024 * s * 127), 0)) begin bad++; $display("FAIL single_sample[%0d]: got %0d want %0d", s, sample, exp_sample(longint'(1024 * s * 127), 0)); end
      total++; if (active !== 7'd1) begin bad++; $display("FAIL single_active[%0d]: got %0d want 1", s, active); end
      total++; if (lut_addr !== 11'(32 * s)) begin bad++; $display("FAIL single_addr[%0d]: got %0d want %0d", s, lut_addr, 32 * s); end
    end
  endtask

  task automatic test_nyquist();
    set_cfg(24'd1 << 22, 7'd8, 7'd0, 3'd0, 1'b0, 16'd1000);
    total++; if (active !== 7'd1) begin bad++; $display("FAIL nyq_active_a: got %0d want 1", active); end
    total++; if (sample !== 16'd33760) begin bad++; $display("FAIL nyq_sample_a: got %0d want 33760", sample); end
    set_cfg(24'd1 << 20, 7'd8, 7'd0, 3'd0, 1'b0, 16'd1000);
    total++; if (active !== 7'd7) begin bad++; $display("FAIL nyq_active_b: got %0d want 7", active); end
    total++; if (sample !== exp_sample(7 * 127000, 0)) begin bad++; $display("FAIL nyq_sample_b: got %0d want %0d", sample, exp_sample(7 * 127000, 0)); end
    set_cfg(24'd1 << 20, 7'd3, 7'd0, 3'd0, 1'b0, 16'd1000);
    total++; if (active !== 7'd3) begin bad++; $display("FAIL harm_limit: got %0d want 3", active); end
  endtask

  task automatic test_rolloff();
    set_cfg(24'd1, 7'd64, 7'd20, 3'd0, 1'b0, 16'd1000);
    total++; if (active !== 7'd7) begin bad++; $display("FAIL roll_active: got %0d want 7", active); end
    total++; if (sample !== 16'd36432) begin bad++; $display("FAIL roll_sample: got %0d want 36432", sample); end
    set_cfg(24'd1, 7'd64, 7'd20, 3'd2, 1'b0, 16'd1000);
    total++; if (sample !== 16'd33684) begin bad++; $display("FAIL roll_shift: got %0d want 33684", sample); end
  endtask

  task automatic test_saturation();
    set_cfg(24'd1, 7'd64, 7'd0, 3'd0, 1'b0, 16'h7fff);
    total++; if (sample !== 16'd65535) begin bad++; $display("FAIL sat_pos: got %0d want 65535", sample); end
    total++; if (active !== 7'd64) begin bad++; $display("FAIL sat_active: got %0d want 64", active); end
    set_cfg(24'd1, 7'd64, 7'd0, 3'd0, 1'b0, 16'h8000);
    total++; if (sample !== 16'd0) begin bad++; $display("FAIL sat_neg: got %0d want 0", sample); end
  endtask

  task automatic test_sync();
    int n;
    set_cfg(24'd1 << 18, 7'd4, 7'd0, 3'd0, 1'b1, 16'd0);
    repeat (10) @(negedge clock);
    sync = 1'b1;
    @(negedge clock);
    sync = 1'b0;
    wait_valid(n);
    wait_valid(n);
    total++; if (sample !== 16'd32768) begin bad++; $display("FAIL sync_sample: got %0d want 32768", sample); end
    total++; if (active !== 7'd4) begin bad++; $display("FAIL sync_active: got %0d want 4", active); end
    total++; if (lut_addr !== 11'd0) begin bad++; $display("FAIL sync_addr: got %0d want 0", lut_addr); end
    wait_valid(n);
    total++; if (sample !== 16'd42928) begin bad++; $display("FAIL post_sync_sample: got %0d want 42928", sample); end
    total++; if (lut_addr !== 11'd128) begin bad++; $display("FAIL post_sync_addr: got %0d want 128", lut_addr); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (dbg_state !== MAC && n < 3 * SI) begin
      @(negedge clock);
      n++;
    end
    total++; if (dbg_state !== MAC) begin bad++; $display("FAIL mac_reach: got state %0d want %0d", dbg_state, MAC); end
    rstn = 1'b0;
    #1;
    total++; if (sample !== 16'd32768) begin bad++; $display("FAIL mid_rst_sample: got %0d want 32768", sample); end
    total++; if (active !== 7'd0) begin bad++; $display("FAIL mid_rst_active: got %0d want 0", active); end
    total++; if (lut_addr !== 11'd0) begin bad++; $display("FAIL mid_rst_addr: got %0d want 0", lut_addr); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL mid_rst_state: got %0d want %0d", dbg_state, IDLE); end
    @(negedge clock);
    rstn = 1'b1;
    wait_valid(n);
    total++; if (n !== SI) begin bad++; $display("FAIL mid_rst_tick: got %0d clocks want %0d", n, SI); end
    total++; if (active !== 7'd0) begin bad++; $display("FAIL mid_rst_republish: got %0d want 0", active); end
    wait_valid(n);
    total++; if (sample !== 16'd32768) begin bad++; $display("FAIL mid_rst_phase_clear: got %0d want 32768", sample); end
    total++; if (active !== 7'd4) begin bad++; $display("FAIL mid_rst_active2: got %0d want 4", active); end
  endtask

  initial begin
    phase_inc = '0; harm_count = '0; decay = '0; shift = '0; sync = 1'b0;
    lut_ramp = 1'b0; lut_const = '0;
    test_reset();
    test_single();
    test_nyquist();
    test_rolloff();
    test_saturation();
    test_sync();
    test_reset_mid();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_final: got %0b want 0", overrun); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
